map_row_clear: RTL and testbench

Line-clear engine for the TetriSaraj playfield, sitting directly upstream of the 40x30 character map RAM. It shares the RAM's write port and one read port, owned by the game logic during a lock.
- On a `start` pulse it scans the playfield rectangle bottom-up for rows with no empty cell.
- Each full row is removed by shifting every row above it down by one and blanking the top row.
- When finished it reports how many lines were cleared, for scoring and level logic.

---
 rtl/tetris_pkg.sv | 35 +++
 rtl/map_row_clear_if.sv | 21 ++
 rtl/map_addr_calc.sv | 24 ++
 rtl/map_row_clear.sv | 252 +++++++++++++++++++++++++
 tb/tb_map_row_clear.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared TetriSaraj definitions: map geometry, default playfield placement,
// the empty-cell id and the line-clear FSM state encoding.
package tetris_pkg;

    localparam int MAP_COLS   = 40;
    localparam int MAP_ROWS   = 30;
    localparam int MAP_ADDR_W = 12;
    localparam int CELL_W     = 4;

    localparam int DEF_FIELD_X0 = 15;
    localparam int DEF_FIELD_W  = 10;
    localparam int DEF_FIELD_Y0 = 5;
    localparam int DEF_FIELD_H  = 20;

    localparam logic [CELL_W-1:0] DEF_EMPTY_ID = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_CLEAR_TOP = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        logic [4:0] r;
        if (v == 5'd31) begin
            r = v;
        end else begin
            r = v + 5'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/map_row_clear_if.sv
// Character map RAM port pair (one read, one write) as seen by a map client.
interface map_row_clear_if;

    logic                              ren;
    logic [tetris_pkg::MAP_ADDR_W-1:0] raddr;
    logic [tetris_pkg::CELL_W-1:0]     rdata;
    logic                              wen;
    logic [tetris_pkg::MAP_ADDR_W-1:0] waddr;
    logic [tetris_pkg::CELL_W-1:0]     wdata;

    modport master (
        output ren, raddr, wen, waddr, wdata,
        input  rdata
    );

    modport slave (
        input  ren, raddr, wen, waddr, wdata,
        output rdata
    );

endinterface

// File: rtl/map_addr_calc.sv
// Linear map address row*MAP_W + col; the default 40-cell pitch uses shift-add.
module map_addr_calc #(
    parameter int MAP_W = tetris_pkg::MAP_COLS
) (
    input  logic [4:0]  row,
    input  logic [5:0]  col,
    output logic [11:0] addr
);

    logic [11:0] row_ext_s;
    logic [11:0] col_ext_s;

    assign row_ext_s = {7'd0, row};
    assign col_ext_s = {6'd0, col};

    generate
        if (MAP_W == 40) begin : g_shift_add
            assign addr = (row_ext_s << 3'd5) + (row_ext_s << 3'd3) + col_ext_s;
        end else begin : g_mul
            assign addr = 12'(row_ext_s * 12'(MAP_W)) + col_ext_s;
        end
    endgenerate

endmodule

// File: rtl/map_row_clear.sv
// Line-clear engine: scans the playfield bottom-up, collapses every full row
// in the character map RAM and reports how many rows were removed.
module map_row_clear
    import tetris_pkg::*;
#(
    parameter int         MAP_W    = tetris_pkg::MAP_COLS,
    parameter int         FIELD_X0 = tetris_pkg::DEF_FIELD_X0,
    parameter int         FIELD_W  = tetris_pkg::DEF_FIELD_W,
    parameter int         FIELD_Y0 = tetris_pkg::DEF_FIELD_Y0,
    parameter int         FIELD_H  = tetris_pkg::DEF_FIELD_H,
    parameter logic [3:0] EMPTY_ID = tetris_pkg::DEF_EMPTY_ID
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared,
    map_row_clear_if.master   map
);

    localparam logic [4:0] ROW_BOT  = 5'(FIELD_Y0 + FIELD_H - 1);
    localparam logic [4:0] ROW_TOP  = 5'(FIELD_Y0);
    localparam logic [4:0] ROW_TOP1 = 5'(FIELD_Y0 + 1);
    localparam logic [5:0] COL_BASE = 6'(FIELD_X0);
    localparam logic [5:0] COL_LAST = 6'(FIELD_W - 1);

    state_t      state_r, state_nxt_s;
    logic [4:0]  row_r, row_nxt_s;
    logic [4:0]  dst_r, dst_nxt_s;
    logic [4:0]  lines_r, lines_nxt_s;
    logic [5:0]  col_r, col_nxt_s;
    logic [5:0]  wcol_r, wcol_nxt_s;
    logic        chk_r, chk_nxt_s;
    logic        chk_last_r, chk_last_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic        ren_r, ren_nxt_s;
    logic        wen_r, wen_nxt_s;
    logic        wsel_r, wsel_nxt_s;
    logic [3:0]  wdata_r, wdata_nxt_s;
    logic [11:0] raddr_r, waddr_r;
    logic [11:0] rd_addr_s, wr_addr_s;
    logic [4:0]  rd_row_s, wr_row_s;
    logic [5:0]  rd_col_s, wr_col_s;
    logic        cell_empty_s;

    map_addr_calc #(.MAP_W(MAP_W)) u_rd_addr (
        .row  (rd_row_s),
        .col  (rd_col_s),
        .addr (rd_addr_s)
    );

    map_addr_calc #(.MAP_W(MAP_W)) u_wr_addr (
        .row  (wr_row_s),
        .col  (wr_col_s),
        .addr (wr_addr_s)
    );

    assign cell_empty_s  = (map.rdata == EMPTY_ID);
    assign busy          = busy_r;
    assign done          = done_r;
    assign lines_cleared = lines_r;
    assign map.ren       = ren_r;
    assign map.raddr     = raddr_r;
    assign map.wen       = wen_r;
    assign map.waddr     = waddr_r;
    // Shift writes forward the read data in the cycle it arrives from the RAM.
    assign map.wdata     = wsel_r ? map.rdata : wdata_r;

    // Next-state and next-output logic for the scan / shift / clear sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        row_nxt_s      = row_r;
        dst_nxt_s      = dst_r;
        lines_nxt_s    = lines_r;
        col_nxt_s      = col_r;
        wcol_nxt_s     = wcol_r;
        chk_nxt_s      = 1'b0;
        chk_last_nxt_s = 1'b0;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        ren_nxt_s      = 1'b0;
        wen_nxt_s      = 1'b0;
        wsel_nxt_s     = 1'b0;
        wdata_nxt_s    = wdata_r;
        rd_row_s       = row_r;
        rd_col_s       = COL_BASE;
        wr_row_s       = dst_r;
        wr_col_s       = COL_BASE;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SCAN;
                    busy_nxt_s  = 1'b1;
                    lines_nxt_s = 5'd0;
                    row_nxt_s   = ROW_BOT;
                    col_nxt_s   = 6'd0;
                    ren_nxt_s   = 1'b1;
                    rd_row_s    = ROW_BOT;
                    rd_col_s    = COL_BASE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SCAN: begin
                if (chk_r && cell_empty_s) begin
                    // Row has a hole; any read still in flight is simply ignored.
                    if (row_r == ROW_TOP) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        row_nxt_s = row_r - 5'd1;
                        col_nxt_s = 6'd0;
                        ren_nxt_s = 1'b1;
                        rd_row_s  = row_r - 5'd1;
                        rd_col_s  = COL_BASE;
                    end
                end else if (chk_r && chk_last_r) begin
                    lines_nxt_s = sat_inc5(lines_r);
                    dst_nxt_s   = row_r;
                    if (row_r == ROW_TOP) begin
                        state_nxt_s = ST_CLEAR_TOP;
                        wen_nxt_s   = 1'b1;
                        wcol_nxt_s  = 6'd0;
                        wdata_nxt_s = EMPTY_ID;
                        wr_row_s    = ROW_TOP;
                        wr_col_s    = COL_BASE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                        col_nxt_s   = 6'd0;
                        ren_nxt_s   = 1'b1;
                        rd_row_s    = row_r - 5'd1;
                        rd_col_s    = COL_BASE;
                    end
                end else begin
                    chk_nxt_s      = 1'b1;
                    chk_last_nxt_s = (col_r == COL_LAST);
                    if (col_r != COL_LAST) begin
                        ren_nxt_s = 1'b1;
                        col_nxt_s = col_r + 6'd1;
                        rd_row_s  = row_r;
                        rd_col_s  = COL_BASE + col_r + 6'd1;
                    end else begin
                        ren_nxt_s = 1'b0;
                    end
                end
            end

            ST_SHIFT: begin
                if (wen_r && (wcol_r == COL_LAST)) begin
                    if (dst_r == ROW_TOP1) begin
                        state_nxt_s = ST_CLEAR_TOP;
                        wen_nxt_s   = 1'b1;
                        wcol_nxt_s  = 6'd0;
                        wdata_nxt_s = EMPTY_ID;
                        wr_row_s    = ROW_TOP;
                        wr_col_s    = COL_BASE;
                    end else begin
                        dst_nxt_s = dst_r - 5'd1;
                        col_nxt_s = 6'd0;
                        ren_nxt_s = 1'b1;
                        rd_row_s  = dst_r - 5'd2;
                        rd_col_s  = COL_BASE;
                    end
                end else begin
                    wen_nxt_s  = 1'b1;
                    wsel_nxt_s = 1'b1;
                    wcol_nxt_s = col_r;
                    wr_row_s   = dst_r;
                    wr_col_s   = COL_BASE + col_r;
                    if (col_r != COL_LAST) begin
                        ren_nxt_s = 1'b1;
                        col_nxt_s = col_r + 6'd1;
                        rd_row_s  = dst_r - 5'd1;
                        rd_col_s  = COL_BASE + col_r + 6'd1;
                    end else begin
                        ren_nxt_s = 1'b0;
                    end
                end
            end

            ST_CLEAR_TOP: begin
                if (wcol_r == COL_LAST) begin
                    // Rescan the same row: it now holds whatever slid down into it.
                    state_nxt_s = ST_SCAN;
                    col_nxt_s   = 6'd0;
                    ren_nxt_s   = 1'b1;
                    rd_row_s    = row_r;
                    rd_col_s    = COL_BASE;
                end else begin
                    wen_nxt_s  = 1'b1;
                    wcol_nxt_s = wcol_r + 6'd1;
                    wr_row_s   = ROW_TOP;
                    wr_col_s   = COL_BASE + wcol_r + 6'd1;
                end
            end

            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b1;
                busy_nxt_s  = 1'b0;
            end

            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            row_r      <= 5'd0;
            dst_r      <= 5'd0;
            lines_r    <= 5'd0;
            col_r      <= 6'd0;
            wcol_r     <= 6'd0;
            chk_r      <= 1'b0;
            chk_last_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ren_r      <= 1'b0;
            wen_r      <= 1'b0;
            wsel_r     <= 1'b0;
            wdata_r    <= 4'h0;
            raddr_r    <= 12'd0;
            waddr_r    <= 12'd0;
        end else begin
            state_r    <= state_nxt_s;
            row_r      <= row_nxt_s;
            dst_r      <= dst_nxt_s;
            lines_r    <= lines_nxt_s;
            col_r      <= col_nxt_s;
            wcol_r     <= wcol_nxt_s;
            chk_r      <= chk_nxt_s;
            chk_last_r <= chk_last_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            ren_r      <= ren_nxt_s;
            wen_r      <= wen_nxt_s;
            wsel_r     <= wsel_nxt_s;
            wdata_r    <= wdata_nxt_s;
            raddr_r    <= ren_nxt_s ? rd_addr_s : raddr_r;
            waddr_r    <= wen_nxt_s ? wr_addr_s : waddr_r;
        end
    end

endmodule

// File: tb/tb_map_row_clear.sv
// Bench for map_row_clear: behavioural map RAM, row-compaction reference model,
// directed playfield scenarios plus randomized playfields.
module tb_map_row_clear;

    localparam int W     = 10;
    localparam int X0    = 15;
    localparam int Y0    = 5;
    localparam int H     = 20;
    localparam int PITCH = 40;
    localparam int NCELL = 1200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;

    map_row_clear_if map_bus ();

    map_row_clear dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .map           (map_bus.master)
    );

    always #5 clk = ~clk;

    logic [3:0] mem     [0:NCELL-1];
    logic [3:0] img     [0:NCELL-1];
    logic [3:0] exp_mem [0:NCELL-1];
    logic       do_load = 1'b0;
    int wr_cnt = 0, done_cnt = 0, bad_rd = 0, bad_wr = 0, bad_col = 0;
    int n_assert = 0, n_fail = 0;
    int last_writes, last_cycles;

    function automatic bit in_field(input logic [11:0] a);
        int r, c;
        r = int'(a) / PITCH;
        c = int'(a) % PITCH;
        return (r >= Y0) && (r < Y0 + H) && (c >= X0) && (c < X0 + W);
    endfunction

    // Map RAM model with one-cycle read latency plus access-legality counters.
    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < NCELL; i++) mem[i] <= img[i];
        end else begin
            if (map_bus.ren) begin
                if (!in_field(map_bus.raddr)) bad_rd <= bad_rd + 1;
                map_bus.rdata <= (int'(map_bus.raddr) < NCELL) ? mem[map_bus.raddr] : 4'h0;
            end
            if (map_bus.wen) begin
                wr_cnt <= wr_cnt + 1;
                if (!in_field(map_bus.waddr)) bad_wr <= bad_wr + 1;
                if (int'(map_bus.waddr) < NCELL) mem[map_bus.waddr] <= map_bus.wdata;
            end
            if (map_bus.ren && map_bus.wen && (map_bus.raddr == map_bus.waddr))
                bad_col <= bad_col + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int cell_idx(input int r, input int c);
        return r * PITCH + X0 + c;
    endfunction

    // Outside the playfield: random non-empty ids; playfield: empty.
    task automatic clear_img();
        for (int a = 0; a < NCELL; a++)
            img[a] = in_field(12'(a)) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    task automatic fill_row(input int r, input logic [3:0] id);
        for (int c = 0; c < W; c++) img[cell_idx(r, c)] = id;
    endtask

    task automatic build_random();
        int sel;
        clear_img();
        for (int r = Y0; r < Y0 + H; r++) begin
            sel = $urandom_range(0, 3);
            for (int c = 0; c < W; c++) begin
                case (sel)
                    0:       img[cell_idx(r, c)] = 4'h0;
                    1:       img[cell_idx(r, c)] = 4'($urandom_range(1, 15));
                    default: img[cell_idx(r, c)] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                endcase
            end
        end
    endtask

    // Final map: surviving rows keep their order and sink to the bottom.
    task automatic model_compact(output int lines);
        int  dst;
        bit  full;
        lines = 0;
        dst = Y0 + H - 1;
        for (int a = 0; a < NCELL; a++) exp_mem[a] = img[a];
        for (int r = Y0 + H - 1; r >= Y0; r--) begin
            full = 1'b1;
            for (int c = 0; c < W; c++) if (img[cell_idx(r, c)] == 4'h0) full = 1'b0;
            if (full) lines++;
            else begin
                for (int c = 0; c < W; c++) exp_mem[cell_idx(dst, c)] = img[cell_idx(r, c)];
                dst--;
            end
        end
        for (int r = dst; r >= Y0; r--)
            for (int c = 0; c < W; c++) exp_mem[cell_idx(r, c)] = 4'h0;
        if (lines > 31) lines = 31;
    endtask

    // Cycle cost from the published per-step costs of scan, shift and clear.
    function automatic int model_cycles();
        logic [3:0] f [0:H-1][0:W-1];
        int row, k, cyc;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) f[r][c] = img[cell_idx(r + Y0, c)];
        row = H - 1;
        cyc = 0;
        while (1) begin
            k = -1;
            for (int c = W - 1; c >= 0; c--) if (f[row][c] == 4'h0) k = c;
            if (k >= 0) begin
                cyc += k + 2;
                if (row == 0) break;
                row--;
            end else begin
                cyc += W + 1;
                for (int d = row; d > 0; d--) begin
                    for (int c = 0; c < W; c++) f[d][c] = f[d-1][c];
                    cyc += W + 1;
                end
                for (int c = 0; c < W; c++) f[0][c] = 4'h0;
                cyc += W;
            end
        end
        return cyc;
    endfunction

    task automatic load_image();
        @(negedge clk); do_load = 1'b1;
        @(negedge clk); do_load = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int pulse_a, input int pulse_b);
        int n, exp_cyc, exp_lines, dc0, wc0, b0, gap, nbad;
        exp_cyc = model_cycles();
        model_compact(exp_lines);
        dc0 = done_cnt; wc0 = wr_cnt; b0 = bad_rd + bad_wr + bad_col;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, ":busy_after_start"}, busy, 1);
        check({tag, ":first_ren"}, map_bus.ren, 1);
        check({tag, ":first_raddr"}, map_bus.raddr, (Y0 + H - 1) * PITCH + X0);
        n = 0;
        gap = 0;
        while (done !== 1'b1 && n < 5000) begin
            start = (n == pulse_a) || (n == pulse_b);
            @(negedge clk);
            n++;
            if (done !== 1'b1 && busy !== 1'b1) gap++;
        end
        start = 1'b0;
        check({tag, ":done_cycle"}, n, exp_cyc + 1);
        check({tag, ":busy_at_done"}, busy, 0);
        check({tag, ":lines"}, lines_cleared, exp_lines);
        check({tag, ":busy_gap"}, gap, 0);
        @(negedge clk);
        check({tag, ":done_pulse_width"}, done, 0);
        repeat (3) @(negedge clk);
        check({tag, ":lines_held"}, lines_cleared, exp_lines);
        check({tag, ":done_count"}, done_cnt - dc0, 1);
        check({tag, ":idle_after"}, busy, 0);
        nbad = 0;
        for (int a = 0; a < NCELL; a++) if (mem[a] !== exp_mem[a]) nbad++;
        check({tag, ":map_mismatches"}, nbad, 0);
        check({tag, ":illegal_accesses"}, bad_rd + bad_wr + bad_col - b0, 0);
        last_writes = wr_cnt - wc0;
        last_cycles = n;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":lines"}, lines_cleared, 0);
        check({tag, ":ren"}, map_bus.ren, 0);
        check({tag, ":wen"}, map_bus.wen, 0);
        check({tag, ":raddr"}, map_bus.raddr, 0);
        check({tag, ":waddr"}, map_bus.waddr, 0);
        check({tag, ":wdata"}, map_bus.wdata, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        clear_img();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Empty field: no writes, done at E0+41.
        load_image();
        run_pass("empty", -1, -1);
        check("empty:writes", last_writes, 0);
        check("empty:done_at_41", last_cycles, 41);

        // Bottom row full, single block above it.
        clear_img();
        fill_row(24, 4'h3);
        img[cell_idx(23, 0)] = 4'h7;
        load_image();
        run_pass("one_line", -1, -1);
        check("one_line:row24_col15", mem[24 * PITCH + 15], 7);
        check("one_line:row24_col16", mem[24 * PITCH + 16], 0);

        // Rows 24 and 22 full, row 23 half full, row 21 patterned.
        clear_img();
        fill_row(24, 4'h3);
        fill_row(22, 4'h5);
        for (int c = 0; c < 5; c++) img[cell_idx(23, c)] = 4'h9;
        for (int c = 0; c < W; c += 2) img[cell_idx(21, c)] = 4'(c + 1);
        load_image();
        run_pass("two_lines", -1, -1);
        check("two_lines:row24_col15", mem[24 * PITCH + 15], 9);
        check("two_lines:row23_col15", mem[23 * PITCH + 15], 1);

        // Only the top row full: clear without any shift.
        clear_img();
        fill_row(5, 4'hA);
        load_image();
        run_pass("top_only", -1, -1);
        check("top_only:writes", last_writes, W);

        // start re-pulsed mid-scan and during the DONE cycle.
        clear_img();
        load_image();
        run_pass("repulse", 10, 40);

        // Reset during SHIFT, then a normal pass.
        clear_img();
        fill_row(24, 4'h3);
        fill_row(23, 4'h6);
        img[cell_idx(22, 4)] = 4'h2;
        load_image();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (map_bus.wen !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid:reached_shift", map_bus.wen, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_image();
        run_pass("after_rst", -1, -1);

        for (int t = 0; t < 6; t++) begin
            build_random();
            load_image();
            run_pass($sformatf("rand%0d", t), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
